// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: datapath width, canonical NOP,
// default reset vector and the fetch packet carried through the fetch FIFO.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_pkt_t;

    // Sequential PC of a word-aligned instruction; wraps modulo 2^32.
    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch packets with push/pop/flush; flush has priority
// over push and pop and returns both pointers to zero.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push_i,
    input  fetch_pkt_t push_pkt_i,
    input  logic       pop_i,
    input  logic       flush_i,
    output fetch_pkt_t head_o,
    output logic       empty_o,
    output logic       full_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] rd_ptr_d;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] wr_ptr_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    fetch_pkt_t    mem_q [DEPTH];

    // Next-state pointer and occupancy logic; pointers wrap naturally at DEPTH.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = {PW{1'b0}};
            wr_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= {PW{1'b0}};
            wr_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; cleared on reset so no stale packet survives it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= push_pkt_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == {CW{1'b0}});
    assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the PC, captures the combinational memory
// word into the fetch FIFO and hands {inst, pc, pc+4} to decode.
module ifetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pcplus4
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] last_pc_q;
    logic [31:0] last_pc4_q;
    logic        enq_s;
    logic        deq_s;
    logic        fifo_empty_s;
    logic        fifo_full_s;
    fetch_pkt_t  push_pkt_s;
    fetch_pkt_t  head_s;

    assign inst_valid = !fifo_empty_s;
    assign deq_s      = inst_valid & inst_ready;
    // A full FIFO still accepts a word when its head leaves in the same cycle.
    assign enq_s      = !redirect_valid & (!fifo_full_s | deq_s);
    assign push_pkt_s = '{inst: imem_rdata, pc: pc_q};
    assign imem_addr  = pc_q;

    fetch_fifo #(
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_i     (enq_s),
        .push_pkt_i (push_pkt_s),
        .pop_i      (deq_s),
        .flush_i    (redirect_valid),
        .head_o     (head_s),
        .empty_o    (fifo_empty_s),
        .full_o     (fifo_full_s)
    );

    // Next-PC selection: redirect beats sequential advance; otherwise hold.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc & 32'hFFFF_FFFC;
        end else if (enq_s) begin
            pc_d = pc_plus4(pc_q);
        end else begin
            pc_d = pc_q;
        end
    end

    // PC register plus the last presented pc/pc+4, shown while the FIFO is empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q       <= RESET_PC & 32'hFFFF_FFFC;
            last_pc_q  <= 32'h0000_0000;
            last_pc4_q <= 32'h0000_0000;
        end else begin
            pc_q <= pc_d;
            if (inst_valid) begin
                last_pc_q  <= head_s.pc;
                last_pc4_q <= pc_plus4(head_s.pc);
            end
        end
    end

    // Decode-facing outputs taken from the FIFO head registers.
    always_comb begin
        inst         = NOP_INST;
        inst_pc      = last_pc_q;
        inst_pcplus4 = last_pc4_q;
        if (inst_valid) begin
            inst         = head_s.inst;
            inst_pc      = head_s.pc;
            inst_pcplus4 = pc_plus4(head_s.pc);
        end else begin
            inst         = NOP_INST;
            inst_pc      = last_pc_q;
            inst_pcplus4 = last_pc4_q;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Table-driven bench for ifetch_unit: streaming, backpressure, redirects,
// PC wrap at the top of the address space and asynchronous mid-stream reset.
module tb_ifetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] einst;
        logic [31:0] epc;
        logic [31:0] epc4;
        logic [31:0] eaddr;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a_n, rv_a, rdy_a, v_a;
    logic [31:0] addr_a, rdata_a, rpc_a, inst_a, pc_a, pc4_a;
    logic        rst_b_n, rv_b, rdy_b, v_b;
    logic [31:0] addr_b, rdata_b, rpc_b, inst_b, pc_b, pc4_b;

    // Memory model: word at byte address A holds A/4.
    assign rdata_a = {2'b00, addr_a[31:2]};
    assign rdata_b = {2'b00, addr_b[31:2]};

    ifetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut_a (
        .clk(clk), .reset_n(rst_a_n), .imem_addr(addr_a), .imem_rdata(rdata_a),
        .redirect_valid(rv_a), .redirect_pc(rpc_a), .inst_valid(v_a),
        .inst_ready(rdy_a), .inst(inst_a), .inst_pc(pc_a), .inst_pcplus4(pc4_a)
    );

    ifetch_unit #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(2)) dut_b (
        .clk(clk), .reset_n(rst_b_n), .imem_addr(addr_b), .imem_rdata(rdata_b),
        .redirect_valid(rv_b), .redirect_pc(rpc_b), .inst_valid(v_b),
        .inst_ready(rdy_b), .inst(inst_b), .inst_pc(pc_b), .inst_pcplus4(pc4_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    vec_t tab_a[18];
    vec_t tab_b[4];

    function automatic vec_t mk(input logic rv, input logic [31:0] rpc, input logic rdy,
                                input logic ev, input logic [31:0] einst,
                                input logic [31:0] epc, input logic [31:0] epc4,
                                input logic [31:0] eaddr);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.ev = ev;
        v.einst = einst; v.epc = epc; v.epc4 = epc4; v.eaddr = eaddr;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
        end
    endtask

    // Checks the current outputs of the selected DUT, then drives this row's inputs.
    task automatic apply(input vec_t v, input bit sel_b, input int row);
        if (!sel_b) begin
            chk("a_valid", row, {31'd0, v_a}, {31'd0, v.ev});
            chk("a_inst",  row, inst_a, v.einst);
            chk("a_pc",    row, pc_a,   v.epc);
            chk("a_pc4",   row, pc4_a,  v.epc4);
            chk("a_addr",  row, addr_a, v.eaddr);
            rv_a = v.rv; rpc_a = v.rpc; rdy_a = v.rdy;
        end else begin
            chk("b_valid", row, {31'd0, v_b}, {31'd0, v.ev});
            chk("b_inst",  row, inst_b, v.einst);
            chk("b_pc",    row, pc_b,   v.epc);
            chk("b_pc4",   row, pc4_b,  v.epc4);
            chk("b_addr",  row, addr_b, v.eaddr);
            rv_b = v.rv; rpc_b = v.rpc; rdy_b = v.rdy;
        end
    endtask

    initial begin
        // Stream, 5-cycle stall, redirect with 2 entries, redirect+deq while full.
        tab_a[0]  = mk(1'b0, 32'h0,   1'b1, 1'b0, NOP,       32'h0,   32'h0,   32'h0);
        tab_a[1]  = mk(1'b0, 32'h0,   1'b1, 1'b1, 32'h0,     32'h0,   32'h4,   32'h4);
        tab_a[2]  = mk(1'b0, 32'h0,   1'b1, 1'b1, 32'h1,     32'h4,   32'h8,   32'h8);
        tab_a[3]  = mk(1'b0, 32'h0,   1'b0, 1'b1, 32'h2,     32'h8,   32'hC,   32'hC);
        tab_a[4]  = mk(1'b0, 32'h0,   1'b0, 1'b1, 32'h2,     32'h8,   32'hC,   32'h10);
        tab_a[5]  = mk(1'b0, 32'h0,   1'b0, 1'b1, 32'h2,     32'h8,   32'hC,   32'h10);
        tab_a[6]  = mk(1'b0, 32'h0,   1'b0, 1'b1, 32'h2,     32'h8,   32'hC,   32'h10);
        tab_a[7]  = mk(1'b0, 32'h0,   1'b0, 1'b1, 32'h2,     32'h8,   32'hC,   32'h10);
        tab_a[8]  = mk(1'b0, 32'h0,   1'b1, 1'b1, 32'h2,     32'h8,   32'hC,   32'h10);
        tab_a[9]  = mk(1'b0, 32'h0,   1'b1, 1'b1, 32'h3,     32'hC,   32'h10,  32'h14);
        tab_a[10] = mk(1'b1, 32'h103, 1'b0, 1'b1, 32'h4,     32'h10,  32'h14,  32'h18);
        tab_a[11] = mk(1'b0, 32'h0,   1'b1, 1'b0, NOP,       32'h10,  32'h14,  32'h100);
        tab_a[12] = mk(1'b0, 32'h0,   1'b1, 1'b1, 32'h40,    32'h100, 32'h104, 32'h104);
        tab_a[13] = mk(1'b0, 32'h0,   1'b0, 1'b1, 32'h41,    32'h104, 32'h108, 32'h108);
        tab_a[14] = mk(1'b1, 32'h200, 1'b1, 1'b1, 32'h41,    32'h104, 32'h108, 32'h10C);
        tab_a[15] = mk(1'b0, 32'h0,   1'b1, 1'b0, NOP,       32'h104, 32'h108, 32'h200);
        tab_a[16] = mk(1'b0, 32'h0,   1'b1, 1'b1, 32'h80,    32'h200, 32'h204, 32'h204);
        tab_a[17] = mk(1'b0, 32'h0,   1'b1, 1'b1, 32'h81,    32'h204, 32'h208, 32'h208);

        // Streaming across the 2^32 wrap.
        tab_b[0] = mk(1'b0, 32'h0, 1'b1, 1'b0, NOP,          32'h0,         32'h0,         32'hFFFF_FFF8);
        tab_b[1] = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h3FFF_FFFE, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        tab_b[2] = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h3FFF_FFFF, 32'hFFFF_FFFC, 32'h0,         32'h0);
        tab_b[3] = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h0,         32'h0,         32'h4,         32'h4);

        rst_a_n = 1'b0; rv_a = 1'b0; rpc_a = 32'h0; rdy_a = 1'b0;
        rst_b_n = 1'b0; rv_b = 1'b0; rpc_b = 32'h0; rdy_b = 1'b0;
        repeat (2) @(negedge clk);

        chk("a_rst_valid", -1, {31'd0, v_a}, 32'd0);
        chk("a_rst_inst",  -1, inst_a, NOP);
        chk("a_rst_pc",    -1, pc_a,   32'h0);
        chk("a_rst_pc4",   -1, pc4_a,  32'h0);
        chk("a_rst_addr",  -1, addr_a, 32'h0);
        chk("b_rst_valid", -1, {31'd0, v_b}, 32'd0);
        chk("b_rst_inst",  -1, inst_b, NOP);
        chk("b_rst_pc",    -1, pc_b,   32'h0);
        chk("b_rst_pc4",   -1, pc4_b,  32'h0);
        chk("b_rst_addr",  -1, addr_b, 32'hFFFF_FFF8);

        rst_a_n = 1'b1;
        for (int i = 0; i < 18; i++) begin
            apply(tab_a[i], 1'b0, i);
            @(negedge clk);
        end

        // Head is {0x82, 0x208}; reset lands between edges and must act at once.
        chk("a_pre_rst_valid", 100, {31'd0, v_a}, 32'd1);
        chk("a_pre_rst_addr",  100, addr_a, 32'h20C);
        #2;
        rst_a_n = 1'b0;
        #1;
        chk("a_async_valid", 101, {31'd0, v_a}, 32'd0);
        chk("a_async_addr",  101, addr_a, 32'h0);
        chk("a_async_inst",  101, inst_a, NOP);
        chk("a_async_pc",    101, pc_a,   32'h0);
        @(negedge clk);
        chk("a_held_valid",  102, {31'd0, v_a}, 32'd0);

        rst_b_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            apply(tab_b[i], 1'b1, i);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction-fetch stage that sits directly upstream of the combinational instruction memory. It owns the program counter and drives the word address into the memory. It captures the returned instruction word into a small FIFO and presents {instruction, PC, PC+4} to decode through a valid/ready handshake. It also accepts branch/jump redirects from execute, which flush the FIFO.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- QDEPTH, 2, fetch FIFO entries; power of two, 2..8.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- imem_addr  out  32  byte address to instruction memory; equals PC register, bits [1:0] always 0.
- imem_rdata  in  32  instruction word, combinationally valid in the same cycle as imem_addr.
- redirect_valid  in  1  one-cycle pulse requesting a PC change.
- redirect_pc  in  32  redirect target; bits [1:0] are ignored and forced to 00.
- inst_valid  out  1  FIFO head holds a valid instruction.
- inst_ready  in  1  decode accepts the head this cycle.
- inst  out  32  head instruction word.
- inst_pc  out  32  PC of the head instruction.
- inst_pcplus4  out  32  inst_pc + 4, modulo 2^32.

## Operation
- State: PC register, FIFO of QDEPTH entries of {inst, pc}, and an occupancy count of $clog2(QDEPTH)+1 bits.
- deq = inst_valid & inst_ready.
- enq = !redirect_valid & (count < QDEPTH | deq). A full FIFO accepts a new entry in the same cycle it pops one.
- On enq: push {imem_rdata, PC}, then PC <= PC + 4. PC wraps from 32'hFFFF_FFFC to 32'h0000_0000 with no flag.
- No enq and no redirect: PC holds, so imem_addr is stable during backpressure.
- On redirect_valid:
  - flush the FIFO (count <= 0, pointers reset);
  - PC <= {redirect_pc[31:2], 2'b00};
  - no enqueue that cycle.
  - A deq in the same cycle is still a legal handshake; decode consumed that head. The flush wins over everything else.
- Outputs are driven from the FIFO head registers. When inst_valid = 0, inst = 32'h0000_0013 (NOP) and inst_pc/inst_pcplus4 hold their last values.
- inst_pcplus4 is computed from the stored pc, not from the PC register.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert at source):
  - PC = RESET_PC, imem_addr = RESET_PC;
  - FIFO empty, inst_valid = 0;
  - inst = 32'h0000_0013, inst_pc = 0, inst_pcplus4 = 0.
- Reset asserted mid-operation clears all state immediately, including in-flight FIFO contents.
- Fetch latency: a word read at cycle N appears on inst with inst_valid = 1 at cycle N+1.
- Steady-state throughput is one instruction per cycle while inst_ready = 1.
- Redirect at cycle N:
  - inst_valid = 0 in N+1, and imem_addr = redirect target in N+1;
  - the first target instruction is valid in N+2.
- Backpressure: inst_valid, inst, inst_pc and inst_pcplus4 must stay stable while inst_valid & !inst_ready. Valid must not drop without a deq or a redirect.
- The first cycle after reset release fetches RESET_PC; its instruction is valid one cycle later.

## Structure
- Shared package riscv_pkg:
  - XLEN = 32;
  - NOP_INST = 32'h0000_0013;
  - DEFAULT_RESET_PC;
  - packed struct fetch_pkt_t {inst, pc}.
- One sub-module: fetch_fifo. It is a synchronous FIFO with push/pop/flush, full/empty, QDEPTH entries and pointer wrap, with the same clk/reset_n.
- PC register, next-PC logic and enq/deq control live in ifetch_unit.

## Test plan
- Reset then stream, inst_ready = 1, memory word[i] = i: inst_pc = 0, 4, 8, … on consecutive cycles starting 1 cycle after release, and inst = 0, 1, 2, ….
- Hold inst_ready = 0 for 5 cycles: the FIFO fills to QDEPTH, imem_addr freezes at 4*QDEPTH, and outputs stay stable. Raise ready: the stream resumes with no gaps or duplicates.
- Redirect to 32'h0000_0103 while the FIFO holds 2 entries: the next cycle has inst_valid = 0 and imem_addr = 32'h0000_0100. One cycle later inst_pc = 32'h100 and inst_pcplus4 = 32'h104.
- Redirect and deq in the same cycle with the FIFO full: the head is consumed exactly once, the FIFO is flushed and no stale PC is delivered.
- RESET_PC = 32'hFFFF_FFF8, streaming: inst_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; inst_pcplus4 for FFFF_FFFC is 0.
- Assert reset_n low mid-stream between clock edges: inst_valid = 0 and imem_addr = RESET_PC immediately, without waiting for clk.
